// File: rtl/cfg_chain_loader_pkg.sv
// Shared types and constants for the configuration chain loader.
//   state_e        loader FSM states
//   TILE_CFG_BITS  config bits held by one switch tile
//   nwords()       host words needed to cover a chain of a given length
package cfg_chain_pkg;

    localparam int unsigned TILE_CFG_BITS = 40;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOW,
        HIGH,
        FIN
    } state_e;

    function automatic int unsigned nwords(input int unsigned len, input int unsigned w);
        return (len + w - 1) / w;
    endfunction

endpackage

// File: rtl/cfg_chain_loader_if.sv
// Host-side bus of the configuration chain loader.
//   start/in_data/in_valid  host -> loader (load request and word stream)
//   in_ready                loader -> host (word accepted on in_valid && in_ready)
//   rb_data/rb_valid        loader -> host (readback words, no backpressure)
//   busy/done               loader -> host (status)
interface cfg_chain_loader_if #(
    parameter int unsigned WORD_W = 8
);
    logic              start;
    logic [WORD_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic [WORD_W-1:0] rb_data;
    logic              rb_valid;
    logic              busy;
    logic              done;

    modport master (
        output start, in_data, in_valid,
        input  in_ready, rb_data, rb_valid, busy, done
    );

    modport slave (
        input  start, in_data, in_valid,
        output in_ready, rb_data, rb_valid, busy, done
    );
endinterface

// File: rtl/cfg_chain_loader_phase_div.sv
// Phase counter for chain_clk generation: counts DIV cycles and ticks on the last one.
//   i_clk    system clock
//   i_rst    synchronous active-high reset
//   i_clear  restart the count (FSM is changing state)
//   o_tick   high in the DIV-th cycle of the current phase
module cfg_phase_div #(
    parameter int unsigned DIV = 2
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clear,
    output logic o_tick
);
    localparam int unsigned CW = $clog2(DIV + 1);

    logic [CW-1:0] r_cnt;

    assign o_tick = (r_cnt == CW'(DIV - 1));

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clear || o_tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end
endmodule

// File: rtl/cfg_chain_loader.sv
// Configuration shift-chain loader for daisy-chained switch tiles.
// Serialises host words MSB first onto the chain, generates the chain clock and
// shift-enable, and returns the chain's previous contents as readback words.
//   i_shift_clk  system clock
//   i_rst        synchronous active-high reset
//   io_host      host bus (start, word stream in, readback out, busy/done)
//   o_chain_clk  registered clock to the tiles
//   o_chain_en   tile shift_en; 1 = tiles disconnected while loading
//   o_chain_i    serial data to the first tile
//   i_chain_o    serial data from the last tile
module cfg_chain_loader
    import cfg_chain_pkg::*;
#(
    parameter int unsigned CHAIN_LEN = TILE_CFG_BITS,
    parameter int unsigned WORD_W    = 8,
    parameter int unsigned DIV       = 2
) (
    input  logic              i_shift_clk,
    input  logic              i_rst,
    cfg_chain_loader_if.slave io_host,
    output logic              o_chain_clk,
    output logic              o_chain_en,
    output logic              o_chain_i,
    input  logic              i_chain_o
);
    localparam int unsigned BCW = $clog2(CHAIN_LEN + 1);
    localparam int unsigned WCW = $clog2(WORD_W + 1);

    state_e            r_state;
    state_e            w_state_d;
    logic              w_tick;
    logic              w_state_chg;
    logic              w_hs;
    logic              w_sample;
    logic              w_hi_exit;
    logic [BCW-1:0]    r_bit_cnt;
    logic [WCW-1:0]    r_wbit;
    logic [WCW-1:0]    r_rb_cnt;
    logic [WORD_W-1:0] r_shift;
    logic [WORD_W-1:0] r_rb;
    logic [WORD_W-1:0] w_rb_next;
    logic [WORD_W-1:0] w_rb_pad;
    logic [WORD_W-1:0] r_rb_data;
    logic              r_rb_valid;
    logic              r_chain_clk;
    logic              r_chain_en;

    cfg_phase_div #(
        .DIV(DIV)
    ) u_phase_div (
        .i_clk  (i_shift_clk),
        .i_rst  (i_rst),
        .i_clear(w_state_chg),
        .o_tick (w_tick)
    );

    assign w_state_chg = (w_state_d != r_state);
    assign w_hs        = (r_state == FETCH) && io_host.in_valid;
    // Sample on the edge that raises chain_clk: chain_o still holds the pre-shift bit.
    assign w_sample    = (r_state == LOW) && w_tick;
    assign w_hi_exit   = (r_state == HIGH) && w_tick;
    assign w_rb_next   = {r_rb[WORD_W-2:0], i_chain_o};
    // Final partial word: collected bits sit in the LSBs, move them up and zero-fill.
    assign w_rb_pad    = r_rb << (WCW'(WORD_W) - r_rb_cnt);

    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            IDLE:  if (io_host.start) w_state_d = FETCH;
            FETCH: if (io_host.in_valid) w_state_d = LOW;
            LOW:   if (w_tick) w_state_d = HIGH;
            HIGH: begin
                if (w_tick) begin
                    if (r_bit_cnt == BCW'(CHAIN_LEN)) begin
                        w_state_d = FIN;
                    end else if (r_wbit == WCW'(WORD_W)) begin
                        w_state_d = FETCH;
                    end else begin
                        w_state_d = LOW;
                    end
                end
            end
            FIN:     w_state_d = IDLE;
            default: w_state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_shift_clk) begin
        if (i_rst) begin
            r_state     <= IDLE;
            r_bit_cnt   <= '0;
            r_wbit      <= '0;
            r_rb_cnt    <= '0;
            r_shift     <= '0;
            r_rb        <= '0;
            r_rb_data   <= '0;
            r_rb_valid  <= 1'b0;
            r_chain_clk <= 1'b0;
            r_chain_en  <= 1'b1;
        end else begin
            r_state     <= w_state_d;
            r_chain_clk <= (w_state_d == HIGH);
            r_rb_valid  <= 1'b0;

            if ((r_state == IDLE) && io_host.start) begin
                r_chain_en <= 1'b1;
                r_bit_cnt  <= '0;
                r_rb_cnt   <= '0;
            end

            if (w_hs) begin
                r_shift <= io_host.in_data;
                r_wbit  <= '0;
            end

            if (w_sample) begin
                r_bit_cnt <= r_bit_cnt + 1'b1;
                r_wbit    <= r_wbit + 1'b1;
                r_rb      <= w_rb_next;
                if (r_rb_cnt == WCW'(WORD_W - 1)) begin
                    r_rb_data  <= w_rb_next;
                    r_rb_valid <= 1'b1;
                    r_rb_cnt   <= '0;
                end else begin
                    r_rb_cnt <= r_rb_cnt + 1'b1;
                end
            end

            if (w_hi_exit && (w_state_d == LOW)) begin
                r_shift <= r_shift << 1;
            end

            if (w_hi_exit && (w_state_d == FIN)) begin
                r_chain_en <= 1'b0;
                if (r_rb_cnt != '0) begin
                    r_rb_data  <= w_rb_pad;
                    r_rb_valid <= 1'b1;
                end
            end
        end
    end

    assign io_host.in_ready = (r_state == FETCH);
    assign io_host.busy     = (r_state != IDLE);
    assign io_host.done     = (r_state == FIN);
    assign io_host.rb_data  = r_rb_data;
    assign io_host.rb_valid = r_rb_valid;
    assign o_chain_clk      = r_chain_clk;
    assign o_chain_en       = r_chain_en;
    assign o_chain_i        = r_shift[WORD_W-1];
endmodule

// File: tb/tb_cfg_chain_loader.sv
// Bench for cfg_chain_loader: an 80-bit chain of two 40-bit tile models and a
// 12-bit chain, scoreboarded readback and direct checks of chain contents/timing.
module tb_cfg_chain_loader;
    import cfg_chain_pkg::*;

    localparam int unsigned NW80 = nwords(80, 8);

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cfg_chain_loader_if #(.WORD_W(8)) bus0 ();
    cfg_chain_loader_if #(.WORD_W(8)) bus1 ();

    logic cclk0, cen0, ci0, co0;
    logic cclk1, cen1, ci1, co1;

    cfg_chain_loader #(.CHAIN_LEN(80), .WORD_W(8), .DIV(2)) dut0 (
        .i_shift_clk(clk), .i_rst(rst), .io_host(bus0),
        .o_chain_clk(cclk0), .o_chain_en(cen0), .o_chain_i(ci0), .i_chain_o(co0)
    );

    cfg_chain_loader #(.CHAIN_LEN(12), .WORD_W(8), .DIV(2)) dut1 (
        .i_shift_clk(clk), .i_rst(rst), .io_host(bus1),
        .o_chain_clk(cclk1), .o_chain_en(cen1), .o_chain_i(ci1), .i_chain_o(co1)
    );

    // Tile models: shift on chain_clk rise while shift_en is high.
    logic [39:0] tile_a = '0;
    logic [39:0] tile_b = '0;
    logic [11:0] m12    = '0;
    assign co0 = tile_b[39];
    assign co1 = m12[11];

    always @(posedge cclk0) begin
        if (cen0) begin
            tile_a <= {tile_a[38:0], ci0};
            tile_b <= {tile_b[38:0], tile_a[39]};
        end
    end

    always @(posedge cclk1) begin
        if (cen1) m12 <= {m12[10:0], ci1};
    end

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0]  rb_q0[$];
    logic [7:0]  rb_q1[$];
    logic [7:0]  rb_e0, rb_e1;
    int          rb_pulses0 = 0;
    int          rb_pulses1 = 0;
    int          rise_cyc0[$];
    int          rises1 = 0;
    logic [11:0] shifted12 = '0;
    int          done_cnt0 = 0;
    logic        prev_cc0 = 1'b0;
    logic        prev_cc1 = 1'b0;

    logic [79:0] exp80 = '0;
    logic [11:0] exp12 = '0;
    logic [7:0]  words80[10];

    // Readback scoreboards and edge monitors, sampled mid-cycle.
    always @(negedge clk) begin
        if (bus0.rb_valid === 1'b1) begin
            rb_pulses0++;
            checks++;
            if (rb_q0.size() == 0) begin
                errors++;
                $display("FAIL rb0_unexpected got %02h want none", bus0.rb_data);
            end else begin
                rb_e0 = rb_q0.pop_front();
                if (bus0.rb_data !== rb_e0) begin
                    errors++;
                    $display("FAIL rb0_data got %02h want %02h", bus0.rb_data, rb_e0);
                end
            end
        end
        if (bus1.rb_valid === 1'b1) begin
            rb_pulses1++;
            checks++;
            if (rb_q1.size() == 0) begin
                errors++;
                $display("FAIL rb1_unexpected got %02h want none", bus1.rb_data);
            end else begin
                rb_e1 = rb_q1.pop_front();
                if (bus1.rb_data !== rb_e1) begin
                    errors++;
                    $display("FAIL rb1_data got %02h want %02h", bus1.rb_data, rb_e1);
                end
            end
        end
        if (cclk0 && !prev_cc0) rise_cyc0.push_back(cyc);
        prev_cc0 = cclk0;
        if (cclk1 && !prev_cc1) begin
            rises1++;
            shifted12 = {shifted12[10:0], ci1};
        end
        prev_cc1 = cclk1;
        if (bus0.done === 1'b1) done_cnt0++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic load80(input int gap_idx);
        logic [79:0] nb;
        int t;
        int n;
        logic gap_bad;
        for (int i = 0; i < 10; i++) nb[79-8*i -: 8] = words80[i];
        for (int i = 0; i < 10; i++) rb_q0.push_back(exp80[79-8*i -: 8]);
        exp80 = nb;
        rise_cyc0.delete();
        @(negedge clk);
        bus0.in_data  = words80[0];
        bus0.in_valid = (gap_idx != 0);
        bus0.start    = 1'b1;
        @(negedge clk);
        bus0.start = 1'b0;
        checks++;
        if (cen0 !== 1'b1 || bus0.busy !== 1'b1) begin
            errors++;
            $display("FAIL load_start en=%b busy=%b want 1 1", cen0, bus0.busy);
        end
        for (int i = 0; i < 10; i++) begin
            t = 0;
            while (bus0.in_ready !== 1'b1 && t < 1000) begin
                @(negedge clk);
                t++;
            end
            if (bus0.in_ready !== 1'b1) begin
                errors++;
                $display("FAIL in_ready_timeout word %0d got 0 want 1", i);
                bus0.in_valid = 1'b0;
                return;
            end
            if (i == gap_idx) begin
                n = rise_cyc0.size();
                gap_bad = 1'b0;
                repeat (20) begin
                    @(negedge clk);
                    if (cclk0 !== 1'b0 || bus0.in_ready !== 1'b1) gap_bad = 1'b1;
                end
                checks++;
                if (gap_bad || rise_cyc0.size() != n) begin
                    errors++;
                    $display("FAIL stall_gap rises %0d want %0d bad=%b", rise_cyc0.size(), n,
                             gap_bad);
                end
                bus0.in_valid = 1'b1;
            end
            @(posedge clk);
            #1;
            if (i < 9) begin
                bus0.in_data  = words80[i+1];
                bus0.in_valid = (i + 1 != gap_idx);
            end else begin
                bus0.in_valid = 1'b0;
            end
        end
        t = 0;
        while (bus0.done !== 1'b1 && t < 1000) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (bus0.done !== 1'b1 || cen0 !== 1'b0) begin
            errors++;
            $display("FAIL done_cycle done=%b en=%b want 1 0", bus0.done, cen0);
        end
        repeat (4) @(negedge clk);
        checks++;
        if ({tile_b, tile_a} !== exp80) begin
            errors++;
            $display("FAIL tile_contents got %h want %h", {tile_b, tile_a}, exp80);
        end
    endtask

    task automatic test_reset();
        logic bad;
        rst = 1'b1;
        bus0.start = 1'b0; bus0.in_valid = 1'b0; bus0.in_data = '0;
        bus1.start = 1'b0; bus1.in_valid = 1'b0; bus1.in_data = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus0.in_ready, bus0.rb_valid, bus0.busy, bus0.done, cclk0, ci0, cen0} !== 7'b0000001)
        begin
            errors++;
            $display("FAIL reset_values got %b want 0000001",
                     {bus0.in_ready, bus0.rb_valid, bus0.busy, bus0.done, cclk0, ci0, cen0});
        end
        rst = 1'b0;
        bad = 1'b0;
        repeat (100) begin
            @(negedge clk);
            if (cen0 !== 1'b1 || cclk0 !== 1'b0 || bus0.in_ready !== 1'b0 || bus0.busy !== 1'b0)
                bad = 1'b1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL idle_hold got a deviation want en=1 clk=0 ready=0 busy=0");
        end
    endtask

    task automatic test_load();
        int d0;
        int n4;
        int n5;
        for (int i = 0; i < 10; i++) words80[i] = 8'hA5 + 8'(i);
        d0 = done_cnt0;
        load80(-1);
        checks++;
        if (rise_cyc0.size() != 80) begin
            errors++;
            $display("FAIL rise_count got %0d want 80", rise_cyc0.size());
        end else begin
            n4 = 0;
            n5 = 0;
            for (int i = 1; i < 80; i++) begin
                if (rise_cyc0[i] - rise_cyc0[i-1] == 4) n4++;
                if (rise_cyc0[i] - rise_cyc0[i-1] == 5) n5++;
            end
            checks++;
            if (n4 != 70 || n5 != 9) begin
                errors++;
                $display("FAIL bit_spacing got n4=%0d n5=%0d want 70 9", n4, n5);
            end
        end
        checks++;
        if (done_cnt0 - d0 != 1) begin
            errors++;
            $display("FAIL done_pulses got %0d want 1", done_cnt0 - d0);
        end
        checks++;
        if (bus0.busy !== 1'b0 || cen0 !== 1'b0) begin
            errors++;
            $display("FAIL after_load busy=%b en=%b want 0 0", bus0.busy, cen0);
        end
    endtask

    task automatic test_readback();
        int p0;
        p0 = rb_pulses0;
        for (int i = 0; i < 10; i++) words80[i] = 8'h00;
        load80(-1);
        checks++;
        if (rb_pulses0 - p0 != 10 || rb_q0.size() != 0) begin
            errors++;
            $display("FAIL rb_pulses got %0d left %0d want 10 0", rb_pulses0 - p0, rb_q0.size());
        end
    endtask

    task automatic test_stall();
        for (int i = 0; i < 10; i++) words80[i] = 8'hA5 + 8'(i);
        load80(3);
        checks++;
        if (rise_cyc0.size() != 80) begin
            errors++;
            $display("FAIL stall_rises got %0d want 80", rise_cyc0.size());
        end
    endtask

    task automatic test_reset_midload();
        logic [79:0] nb;
        int t;
        int idx;
        for (int i = 0; i < 10; i++) words80[i] = 8'h5A ^ 8'(i * 8'h13);
        for (int i = 0; i < 10; i++) nb[79-8*i -: 8] = words80[i];
        for (int i = 0; i < 4; i++) rb_q0.push_back(exp80[79-8*i -: 8]);
        rise_cyc0.delete();
        idx = 0;
        @(negedge clk);
        bus0.in_data  = words80[0];
        bus0.in_valid = 1'b1;
        bus0.start    = 1'b1;
        @(negedge clk);
        bus0.start = 1'b0;
        t = 0;
        while (rise_cyc0.size() < 33 && t < 2000) begin
            if (bus0.in_ready === 1'b1) begin
                @(posedge clk);
                #1;
                if (idx < 9) idx++;
                bus0.in_data = words80[idx];
            end
            @(negedge clk);
            t++;
        end
        rst = 1'b1;
        bus0.in_valid = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (cclk0 !== 1'b0 || cen0 !== 1'b1 || bus0.busy !== 1'b0 || rise_cyc0.size() != 33) begin
            errors++;
            $display("FAIL midload_reset clk=%b en=%b busy=%b rises=%0d want 0 1 0 33",
                     cclk0, cen0, bus0.busy, rise_cyc0.size());
        end
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (rb_q0.size() != 0) begin
            errors++;
            $display("FAIL midload_rb left %0d want 0", rb_q0.size());
        end
        rb_q0.delete();
        exp80 = {exp80[46:0], nb[79:47]};
        repeat (5) @(negedge clk);
        checks++;
        if (cen0 !== 1'b1 || {tile_b, tile_a} !== exp80) begin
            errors++;
            $display("FAIL midload_hold en=%b tile=%h want 1 %h", cen0, {tile_b, tile_a}, exp80);
        end
        load80(-1);
    endtask

    task automatic load12(input int p_want);
        int t;
        int p1;
        p1 = rb_pulses1;
        rb_q1.push_back(exp12[11:4]);
        rb_q1.push_back({exp12[3:0], 4'h0});
        exp12     = 12'hF03;
        rises1    = 0;
        shifted12 = '0;
        @(negedge clk);
        bus1.in_data  = 8'hF0;
        bus1.in_valid = 1'b1;
        bus1.start    = 1'b1;
        @(negedge clk);
        bus1.start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            t = 0;
            while (bus1.in_ready !== 1'b1 && t < 1000) begin
                @(negedge clk);
                t++;
            end
            @(posedge clk);
            #1;
            bus1.in_data  = 8'h3C;
            bus1.in_valid = (i == 0);
        end
        t = 0;
        while (bus1.done !== 1'b1 && t < 1000) begin
            @(negedge clk);
            t++;
        end
        repeat (4) @(negedge clk);
        checks++;
        if (rises1 != 12 || shifted12 !== 12'hF03 || m12 !== 12'hF03) begin
            errors++;
            $display("FAIL short_chain rises=%0d bits=%b tile=%h want 12 111100000011 f03",
                     rises1, shifted12, m12);
        end
        checks++;
        if (rb_pulses1 - p1 != p_want || rb_q1.size() != 0) begin
            errors++;
            $display("FAIL short_rb pulses=%0d left=%0d want %0d 0", rb_pulses1 - p1,
                     rb_q1.size(), p_want);
        end
    endtask

    initial begin
        test_reset();
        test_load();
        test_readback();
        test_stall();
        test_reset_midload();
        load12(2);
        load12(2);
        checks++;
        if (rb_q0.size() != 0) begin
            errors++;
            $display("FAIL rb0_leftover got %0d want 0", rb_q0.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
